// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the 15x16 register file. It round-robins ALU/MEM/MULDIV onto
// the shared op1/write port and the R15 port, and keeps the pending-write scoreboard.
module rf_wb_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              md_valid,
  input  logic [ADDR_W-1:0] md_rd,
  input  logic [DATA_W-1:0] md_lo,
  input  logic [DATA_W-1:0] md_hi,
  output logic              md_ready,
  input  logic [ADDR_W-1:0] dec_op1_addr,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic [ADDR_W-1:0] rf_op1_addr,
  output logic              rf_wr_en,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              rf_r15_en,
  output logic [DATA_W-1:0] rf_r15_data,
  output logic              op1_steal,
  output logic [15:0]       busy,
  output logic              waw_err
);

  localparam int unsigned NREG    = 16;
  localparam int unsigned R15_IDX = 15;
  localparam logic [ADDR_W-1:0] R15 = ADDR_W'(R15_IDX);

  logic [1:0]        r_ptr;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_r15_en;
  logic [DATA_W-1:0] r_r15_data;
  logic [NREG-1:0]   r_busy;
  logic              r_waw;

  logic [2:0]        w_req;
  logic              w_any;
  logic [1:0]        w_win;
  logic [ADDR_W-1:0] w_sel_rd;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_sel_main;
  logic [NREG-1:0]   w_clr;
  logic [NREG-1:0]   w_set;
  logic [NREG-1:0]   w_busy_kept;

  // Requests are masked while in reset so no ready leaks out during rst=0.
  assign w_req = {md_valid, mem_valid, alu_valid} & {3{rst}};
  assign w_any = |w_req;

  // Round-robin pick starting at r_ptr, order 0 -> 1 -> 2 -> 0.
  always_comb begin
    w_win = 2'd0;
    case (r_ptr)
      2'd1: begin
        if (w_req[1])      w_win = 2'd1;
        else if (w_req[2]) w_win = 2'd2;
        else               w_win = 2'd0;
      end
      2'd2: begin
        if (w_req[2])      w_win = 2'd2;
        else if (w_req[0]) w_win = 2'd0;
        else               w_win = 2'd1;
      end
      default: begin
        if (w_req[0])      w_win = 2'd0;
        else if (w_req[1]) w_win = 2'd1;
        else               w_win = 2'd2;
      end
    endcase
  end

  assign alu_ready = w_any && (w_win == 2'd0);
  assign mem_ready = w_any && (w_win == 2'd1);
  assign md_ready  = w_any && (w_win == 2'd2);

  always_comb begin
    w_sel_rd   = alu_rd;
    w_sel_data = alu_data;
    case (w_win)
      2'd1: begin
        w_sel_rd   = mem_rd;
        w_sel_data = mem_data;
      end
      2'd2: begin
        w_sel_rd   = md_rd;
        w_sel_data = md_lo;
      end
      default: ;
    endcase
    // R0 is never written; a MUL/DIV to R15 goes only through the R15 port.
    w_sel_main = (w_sel_rd != '0) && !((w_win == 2'd2) && (w_sel_rd == R15));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr      <= 2'd0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_r15_en   <= 1'b0;
      r_r15_data <= '0;
    end else begin
      r_wr_en  <= w_any && w_sel_main;
      r_r15_en <= w_any && (w_win == 2'd2);
      if (w_any) begin
        r_wr_addr <= w_sel_rd;
        r_wr_data <= w_sel_data;
        r_ptr     <= (w_win == 2'd2) ? 2'd0 : w_win + 2'd1;
      end
      if (w_any && (w_win == 2'd2)) r_r15_data <= md_hi;
    end
  end

  // Scoreboard: commits in the output stage clear, issues set, set wins.
  always_comb begin
    w_clr = '0;
    w_set = '0;
    if (r_wr_en)     w_clr[r_wr_addr] = 1'b1;
    if (r_r15_en)    w_clr[R15_IDX]   = 1'b1;
    if (issue_valid) w_set[issue_rd]  = 1'b1;
    w_busy_kept = r_busy & ~w_clr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
      r_waw  <= 1'b0;
    end else begin
      r_busy <= (w_busy_kept | w_set) & ~NREG'(1);
      if (issue_valid && w_busy_kept[issue_rd]) r_waw <= 1'b1;
    end
  end

  assign rf_wr_en    = r_wr_en;
  assign rf_wr_data  = r_wr_data;
  assign rf_r15_en   = r_r15_en;
  assign rf_r15_data = r_r15_data;
  assign op1_steal   = r_wr_en;
  assign rf_op1_addr = r_wr_en ? r_wr_addr : dec_op1_addr;
  assign busy        = r_busy;
  assign waw_err     = r_waw;

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port, and its dedicated R15 write port, among three writeback requesters: ALU (0), load/MEM (1) and MUL/DIV (2).
- The regfile write port addresses through its op1 read address, so this block also owns the op1 address mux. It flags to decode the cycles in which op1 is taken for a write.
- Keeps a 16-bit pending-write scoreboard for decode hazard checks.
- Sits between the execute/memory stages and the 15×16 register file.

Parameters:
DATA_W, 16, register data width
ADDR_W, 4, register address width (registers 1..15; address 0 is not backed)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
alu_valid  in  1  ALU writeback request
alu_rd  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
alu_ready  out  1  ALU request accepted this cycle
mem_valid  in  1  load writeback request
mem_rd  in  ADDR_W  load destination register
mem_data  in  DATA_W  load data
mem_ready  out  1  load request accepted this cycle
md_valid  in  1  MUL/DIV writeback request
md_rd  in  ADDR_W  destination for low half
md_lo  in  DATA_W  product low / quotient
md_hi  in  DATA_W  product high / remainder, always written to R15
md_ready  out  1  MUL/DIV request accepted this cycle
dec_op1_addr  in  ADDR_W  decode's op1 read address
issue_valid  in  1  decode issues an instruction with a destination
issue_rd  in  ADDR_W  destination of the issued instruction
rf_op1_addr  out  ADDR_W  drives regfile read_op1 (and therefore the write address)
rf_wr_en  out  1  drives regfile regWrite
rf_wr_data  out  DATA_W  drives regfile wrData
rf_r15_en  out  1  drives regfile R15write
rf_r15_data  out  DATA_W  drives regfile wrR15_Data
op1_steal  out  1  op1 port used for a write this cycle; decode must stall
busy  out  16  scoreboard, bit n = pending write to Rn
waw_err  out  1  sticky: issue to an already-busy register

Behaviour:
- Reset (rst=0, async):
  - rf_wr_en=0, rf_r15_en=0, rf_wr_data=0, rf_r15_data=0, op1_steal=0.
  - busy=0, waw_err=0, RR pointer=0, output stage empty.
  - Takes effect mid-transfer: an accepted but uncommitted write is dropped.
- Arbitration (combinational, cycle N):
  - Round-robin over valid requesters, starting at the pointer; order 0→1→2→0.
  - Exactly one ready is asserted, for the winner; none if no requester is valid.
  - After a grant, pointer = winner+1 mod 3. With no grant, the pointer holds.
  - Requesters hold valid/rd/data stable until ready.
- Output stage (registered, cycle N+1):
  - Winner's rd and data are captured at the end of cycle N.
  - In N+1: rf_wr_en=1, rf_op1_addr=captured rd, op1_steal=1. The write commits at the end of N+1, so request-to-commit latency is 2 edges.
  - Otherwise rf_op1_addr=dec_op1_addr and op1_steal=0.
  - Throughput: one write per cycle, back-to-back.
- MUL/DIV grant:
  - Same output cycle also drives rf_r15_en=1, rf_r15_data=md_hi.
  - If md_rd==15: rf_wr_en=0 and only the R15 port writes md_hi; md_lo is discarded.
  - If md_rd==0: md_lo is discarded, and R15 is still written.
- rd==0 on ALU/MEM: handshake completes and the request consumes its grant slot. rf_wr_en stays 0 and op1_steal stays 0.
- Scoreboard:
  - issue_valid sets busy[issue_rd] at the clock edge.
  - Commit of a main-port write to Rn clears busy[n] at the commit edge.
  - R15-port commit clears busy[15].
  - busy[0] is always 0.
  - Set and clear of the same register on the same edge: set wins.
  - issue_valid with busy[issue_rd]=1 and no clear on that edge: waw_err←1, held until reset.
- rf_r15_en is only ever asserted for MUL/DIV grants, so the main port and the R15 port never target R15 in the same cycle.

Test Plan:
- Reset with all valids high → all readys 0 while rst=0; after release the first grant is ALU; busy=0, rf_wr_en=0 throughout reset.
- alu_valid, rd=3, data=0x1234 at cycle N → alu_ready=1 in N; in N+1 rf_wr_en=1, rf_op1_addr=3, rf_wr_data=0x1234, op1_steal=1; N+2 op1_steal=0, rf_op1_addr=dec_op1_addr.
- All three requesters valid continuously (rd 1/2/4) → grants ALU, MEM, MD, ALU on consecutive cycles; back-to-back commits with no idle cycle.
- md rd=5, lo=0xAAAA, hi=0x5555 → one output cycle with rf_wr_en=1/addr 5/0xAAAA and rf_r15_en=1/0x5555; repeat with md_rd=15 → rf_wr_en=0, R15 gets 0x5555 only.
- issue rd=7, then ALU write rd=7 committing on the same edge as a new issue rd=7 → busy[7] stays 1; second issue rd=7 before any commit → waw_err=1, sticky.
- ALU write rd=9 accepted, rst pulsed low in N+1 → rf_wr_en drops immediately, busy=0, no commit after reset release.
